// File: rtl/decode_queue_if.sv
// ============================================================================
// Module   : decode_queue_if
// Brief    : Fetch-side and execute-side handshake bundle of the decode queue.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface decode_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   in_pc;
    logic [31:0]   in_instr;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   out_pc;
    logic [63:0]   out_imm;
    logic [4:0]    out_rs1;
    logic [4:0]    out_rs2;
    logic [4:0]    out_rd;
    logic [3:0]    out_aluop;
    logic          out_srca_pc;
    logic          out_srcb;
    logic          out_rv64;
    logic          out_rvm;
    logic [2:0]    out_mulop;
    logic          out_isbranch;
    logic          out_isjump;
    logic          out_iswb;
    logic          out_memread;
    logic          out_memwrite;
    logic [3:0]    out_memmode;
    logic          out_illegal;
    logic [CW-1:0] count;

    modport master (
        output flush, in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_imm, out_rs1, out_rs2, out_rd,
               out_aluop, out_srca_pc, out_srcb, out_rv64, out_rvm, out_mulop,
               out_isbranch, out_isjump, out_iswb, out_memread, out_memwrite,
               out_memmode, out_illegal, count
    );

    modport slave (
        input  flush, in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_imm, out_rs1, out_rs2, out_rd,
               out_aluop, out_srca_pc, out_srcb, out_rv64, out_rvm, out_mulop,
               out_isbranch, out_isjump, out_iswb, out_memread, out_memwrite,
               out_memmode, out_illegal, count
    );
endinterface

`default_nettype wire

// File: rtl/decode_queue.sv
// ============================================================================
// Module   : decode_queue
// Brief    : DEPTH-entry queue of fully decoded RV64I(+M) instructions.
// Revision : 1.0
// ============================================================================
`default_nettype none

module decode_queue #(
    parameter int DEPTH    = 4,
    parameter int ENABLE_M = 1
) (
    input  wire logic         clk,
    input  wire logic         reset,
    decode_queue_if.slave     q
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);

    localparam logic [6:0] c_OPC_OP      = 7'b0110011;
    localparam logic [6:0] c_OPC_OP32    = 7'b0111011;
    localparam logic [6:0] c_OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] c_OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] c_OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE   = 7'b0100011;
    localparam logic [6:0] c_OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] c_OPC_LUI     = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL     = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR    = 7'b1100111;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  aluop;
        logic        srca_pc;
        logic        srcb;
        logic        rv64;
        logic        rvm;
        logic [2:0]  mulop;
        logic        isbranch;
        logic        isjump;
        logic        iswb;
        logic        memread;
        logic        memwrite;
        logic [3:0]  memmode;
        logic        illegal;
    } dec_t;

    // Register and immediate ALU ops share funct3; alt (instr[30]) selects sub/sra.
    function automatic logic [3:0] f_alu(input logic [2:0] f3, input logic alt,
                                         input logic allow_sub);
        case (f3)
            3'b000:  f_alu = (alt && allow_sub) ? 4'd1 : 4'd0;
            3'b001:  f_alu = 4'd5;
            3'b010:  f_alu = 4'd8;
            3'b011:  f_alu = 4'd9;
            3'b100:  f_alu = 4'd2;
            3'b101:  f_alu = alt ? 4'd7 : 4'd6;
            3'b110:  f_alu = 4'd3;
            default: f_alu = 4'd4;
        endcase
    endfunction

    logic [31:0] w_in;
    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [63:0] w_imm_i;
    logic [63:0] w_imm_s;
    logic [63:0] w_imm_b;
    logic [63:0] w_imm_u;
    logic [63:0] w_imm_j;
    dec_t        w_dec;
    dec_t        w_head;
    logic        w_push;
    logic        w_pop;

    dec_t          r_mem [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;

    assign w_in    = q.in_instr;
    assign w_opc   = w_in[6:0];
    assign w_f3    = w_in[14:12];
    assign w_imm_i = {{52{w_in[31]}}, w_in[31:20]};
    assign w_imm_s = {{52{w_in[31]}}, w_in[31:25], w_in[11:7]};
    assign w_imm_b = {{51{w_in[31]}}, w_in[31], w_in[7], w_in[30:25], w_in[11:8], 1'b0};
    assign w_imm_u = {{32{w_in[31]}}, w_in[31:12], 12'b0};
    assign w_imm_j = {{43{w_in[31]}}, w_in[31], w_in[19:12], w_in[20], w_in[30:21], 1'b0};

    always_comb begin
        w_dec     = '0;
        w_dec.pc  = q.in_pc;
        w_dec.rs1 = w_in[19:15];
        w_dec.rs2 = w_in[24:20];
        w_dec.rd  = w_in[11:7];
        case (w_opc)
            c_OPC_OP, c_OPC_OP32: begin
                if (w_in[31:25] == 7'b0000001) begin
                    if (ENABLE_M != 0) begin
                        w_dec.rvm   = 1'b1;
                        w_dec.mulop = w_f3;
                        w_dec.iswb  = 1'b1;
                        w_dec.rv64  = (w_opc == c_OPC_OP32);
                    end else begin
                        w_dec.illegal = 1'b1;
                    end
                end else begin
                    w_dec.aluop = f_alu(w_f3, w_in[30], 1'b1);
                    w_dec.iswb  = 1'b1;
                    w_dec.rv64  = (w_opc == c_OPC_OP32);
                end
            end
            c_OPC_OPIMM, c_OPC_OPIMM32: begin
                w_dec.aluop = f_alu(w_f3, w_in[30], 1'b0);
                w_dec.srcb  = 1'b1;
                w_dec.iswb  = 1'b1;
                w_dec.rv64  = (w_opc == c_OPC_OPIMM32);
                // Shifts carry a zero-extended shamt; the W form only has 5 bits.
                if (w_f3[1:0] == 2'b01)
                    w_dec.imm = w_dec.rv64 ? {59'b0, w_in[24:20]} : {58'b0, w_in[25:20]};
                else
                    w_dec.imm = w_imm_i;
            end
            c_OPC_LOAD: begin
                w_dec.imm     = w_imm_i;
                w_dec.srcb    = 1'b1;
                w_dec.iswb    = 1'b1;
                w_dec.memread = 1'b1;
            end
            c_OPC_STORE: begin
                w_dec.imm      = w_imm_s;
                w_dec.srcb     = 1'b1;
                w_dec.memwrite = 1'b1;
            end
            c_OPC_BRANCH: begin
                w_dec.imm      = w_imm_b;
                w_dec.isbranch = 1'b1;
                case (w_f3[2:1])
                    2'b10:   w_dec.aluop = 4'd8;
                    2'b11:   w_dec.aluop = 4'd9;
                    default: w_dec.aluop = 4'd1;
                endcase
            end
            c_OPC_LUI: begin
                w_dec.imm   = w_imm_u;
                w_dec.aluop = 4'd10;
                w_dec.srcb  = 1'b1;
                w_dec.iswb  = 1'b1;
            end
            c_OPC_AUIPC: begin
                w_dec.imm     = w_imm_u;
                w_dec.srca_pc = 1'b1;
                w_dec.srcb    = 1'b1;
                w_dec.iswb    = 1'b1;
            end
            c_OPC_JAL: begin
                w_dec.imm     = w_imm_j;
                w_dec.srca_pc = 1'b1;
                w_dec.isjump  = 1'b1;
                w_dec.iswb    = 1'b1;
            end
            c_OPC_JALR: begin
                w_dec.imm     = w_imm_i;
                w_dec.srca_pc = 1'b1;
                w_dec.isjump  = 1'b1;
                w_dec.iswb    = 1'b1;
            end
            default: w_dec.illegal = 1'b1;
        endcase
        w_dec.memmode = {w_dec.memwrite, w_f3};
    end

    assign q.in_ready  = (r_count != c_DEPTH);
    assign q.out_valid = (r_count != '0);
    assign w_push      = q.in_valid && q.in_ready && !q.flush;
    assign w_pop       = q.out_valid && q.out_ready && !q.flush;

    always_ff @(posedge clk) begin
        if (reset || q.flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_tail] <= w_dec;
                r_tail        <= r_tail + AW'(1);
            end
            if (w_pop)
                r_head <= r_head + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head         = r_mem[r_head];
    assign q.out_pc       = w_head.pc;
    assign q.out_imm      = w_head.imm;
    assign q.out_rs1      = w_head.rs1;
    assign q.out_rs2      = w_head.rs2;
    assign q.out_rd       = w_head.rd;
    assign q.out_aluop    = w_head.aluop;
    assign q.out_srca_pc  = w_head.srca_pc;
    assign q.out_srcb     = w_head.srcb;
    assign q.out_rv64     = w_head.rv64;
    assign q.out_rvm      = w_head.rvm;
    assign q.out_mulop    = w_head.mulop;
    assign q.out_isbranch = w_head.isbranch;
    assign q.out_isjump   = w_head.isjump;
    assign q.out_iswb     = w_head.iswb;
    assign q.out_memread  = w_head.memread;
    assign q.out_memwrite = w_head.memwrite;
    assign q.out_memmode  = w_head.memmode;
    assign q.out_illegal  = w_head.illegal;
    assign q.count        = r_count;
endmodule

`default_nettype wire

// File: tb/tb_decode_queue.sv
// ============================================================================
// Module   : tb_decode_queue
// Brief    : Directed bench for decode_queue, with and without the M extension.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_decode_queue;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    decode_queue_if #(.DEPTH(DEPTH)) qif ();
    decode_queue_if #(.DEPTH(DEPTH)) qnm ();

    decode_queue #(.DEPTH(DEPTH), .ENABLE_M(1)) u_dut (
        .clk   (clk),
        .reset (reset),
        .q     (qif.slave)
    );

    decode_queue #(.DEPTH(DEPTH), .ENABLE_M(0)) u_dut_nm (
        .clk   (clk),
        .reset (reset),
        .q     (qnm.slave)
    );

    assign qnm.flush     = qif.flush;
    assign qnm.in_valid  = qif.in_valid;
    assign qnm.in_pc     = qif.in_pc;
    assign qnm.in_instr  = qif.in_instr;
    assign qnm.out_ready = qif.out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] pc, input logic [31:0] instr);
        qif.in_valid = 1'b1;
        qif.in_pc    = pc;
        qif.in_instr = instr;
        tick();
        qif.in_valid = 1'b0;
    endtask

    task automatic pop();
        qif.out_ready = 1'b1;
        tick();
        qif.out_ready = 1'b0;
    endtask

    function automatic logic [31:0] addi(input int k);
        return {12'(k), 5'd0, 3'd0, 5'(k), 7'h13};
    endfunction

    initial begin
        int exp_imm [3];
        exp_imm = '{3, 4, 6};
        reset = 1'b1;
        qif.flush = 1'b0; qif.in_valid = 1'b0; qif.in_pc = '0;
        qif.in_instr = '0; qif.out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_count", qif.count, 0);
        chk("rst_out_valid", qif.out_valid, 0);
        chk("rst_in_ready", qif.in_ready, 1);

        // addi x1,x0,5 with no same-cycle visibility
        qif.in_valid = 1'b1; qif.in_pc = 64'h1000; qif.in_instr = 32'h00500093;
        #1;
        chk("no_comb_path", qif.out_valid, 0);
        tick();
        qif.in_valid = 1'b0;
        chk("addi_valid", qif.out_valid, 1);
        chk("addi_rd", qif.out_rd, 1);
        chk("addi_rs1", qif.out_rs1, 0);
        chk("addi_imm", qif.out_imm, 5);
        chk("addi_aluop", qif.out_aluop, 0);
        chk("addi_srcb", qif.out_srcb, 1);
        chk("addi_iswb", qif.out_iswb, 1);
        chk("addi_count", qif.count, 1);
        chk("addi_pc", qif.out_pc, 64'h1000);
        pop();
        chk("addi_popped", qif.out_valid, 0);

        // sub then sd back-to-back
        push(64'h1004, 32'h402081B3);
        push(64'h1008, 32'h0020B423);
        chk("sub_count", qif.count, 2);
        chk("sub_aluop", qif.out_aluop, 1);
        chk("sub_rd", qif.out_rd, 3);
        chk("sub_rs2", qif.out_rs2, 2);
        chk("sub_pc", qif.out_pc, 64'h1004);
        pop();
        chk("sd_imm", qif.out_imm, 8);
        chk("sd_memwrite", qif.out_memwrite, 1);
        chk("sd_memmode", qif.out_memmode, 4'b1011);
        chk("sd_iswb", qif.out_iswb, 0);
        chk("sd_count", qif.count, 1);
        pop();
        chk("sd_popped", qif.count, 0);

        // Fill to DEPTH across the pointer wrap
        for (int k = 1; k <= DEPTH; k++) push(64'h2000 + 64'(4 * k), addi(k));
        chk("full_count", qif.count, DEPTH);
        chk("full_in_ready", qif.in_ready, 0);
        chk("full_head_imm", qif.out_imm, 1);
        qif.in_valid = 1'b1; qif.in_instr = addi(5);
        tick();
        chk("full_reject", qif.count, DEPTH);
        qif.out_ready = 1'b1;
        tick();
        qif.in_valid = 1'b0; qif.out_ready = 1'b0;
        chk("full_pop_count", qif.count, DEPTH - 1);
        chk("full_pop_ready", qif.in_ready, 1);
        chk("full_pop_head", qif.out_imm, 2);
        qif.in_valid = 1'b1; qif.in_instr = addi(6); qif.out_ready = 1'b1;
        tick();
        qif.in_valid = 1'b0; qif.out_ready = 1'b0;
        chk("pushpop_count", qif.count, DEPTH - 1);
        for (int i = 0; i < 3; i++) begin
            chk("order_imm", qif.out_imm, 64'(exp_imm[i]));
            pop();
        end
        chk("drain_count", qif.count, 0);

        // beq x1,x2,-8 and lui x1,0x12345
        push(64'h3000, 32'hFE208CE3);
        push(64'h3004, 32'h123450B7);
        chk("beq_isbranch", qif.out_isbranch, 1);
        chk("beq_imm", qif.out_imm, 64'hFFFFFFFFFFFFFFF8);
        chk("beq_aluop", qif.out_aluop, 1);
        chk("beq_iswb", qif.out_iswb, 0);
        chk("beq_srcb", qif.out_srcb, 0);
        pop();
        chk("lui_imm", qif.out_imm, 64'h0000000012345000);
        chk("lui_aluop", qif.out_aluop, 10);
        chk("lui_iswb", qif.out_iswb, 1);
        pop();

        // srai x1,x1,33 (6-bit shamt) and sraiw x1,x1,1
        push(64'h3100, 32'h4210D093);
        push(64'h3104, 32'h4010D09B);
        chk("srai_imm", qif.out_imm, 33);
        chk("srai_aluop", qif.out_aluop, 7);
        chk("srai_rv64", qif.out_rv64, 0);
        pop();
        chk("sraiw_imm", qif.out_imm, 1);
        chk("sraiw_aluop", qif.out_aluop, 7);
        chk("sraiw_rv64", qif.out_rv64, 1);
        pop();

        // mul x5,x6,x7 then an all-ones word
        push(64'h3200, 32'h027302B3);
        push(64'h3204, 32'hFFFFFFFF);
        chk("mul_rvm", qif.out_rvm, 1);
        chk("mul_mulop", qif.out_mulop, 0);
        chk("mul_illegal", qif.out_illegal, 0);
        chk("mul_iswb", qif.out_iswb, 1);
        chk("nm_mul_illegal", qnm.out_illegal, 1);
        chk("nm_mul_iswb", qnm.out_iswb, 0);
        chk("nm_mul_rvm", qnm.out_rvm, 0);
        pop();
        chk("ill_illegal", qif.out_illegal, 1);
        chk("ill_iswb", qif.out_iswb, 0);
        chk("ill_mem", {qif.out_memread, qif.out_memwrite}, 0);
        chk("ill_flow", {qif.out_isbranch, qif.out_isjump}, 0);
        chk("nm_ill_illegal", qnm.out_illegal, 1);
        pop();

        // Flush with concurrent push and pop requests
        for (int k = 7; k <= 9; k++) push(64'h4000 + 64'(k), addi(k));
        chk("pre_flush_count", qif.count, 3);
        qif.flush = 1'b1; qif.in_valid = 1'b1; qif.in_instr = addi(10); qif.out_ready = 1'b1;
        tick();
        qif.flush = 1'b0; qif.in_valid = 1'b0; qif.out_ready = 1'b0;
        chk("flush_count", qif.count, 0);
        chk("flush_out_valid", qif.out_valid, 0);
        chk("flush_in_ready", qif.in_ready, 1);
        push(64'h5000, addi(11));
        chk("post_flush_count", qif.count, 1);
        chk("post_flush_imm", qif.out_imm, 11);
        pop();

        // Same sequence with reset
        for (int k = 7; k <= 9; k++) push(64'h6000 + 64'(k), addi(k));
        chk("pre_reset_count", qif.count, 3);
        reset = 1'b1; qif.in_valid = 1'b1; qif.in_instr = addi(10); qif.out_ready = 1'b1;
        tick();
        reset = 1'b0; qif.in_valid = 1'b0; qif.out_ready = 1'b0;
        chk("reset_count", qif.count, 0);
        chk("reset_out_valid", qif.out_valid, 0);
        chk("reset_in_ready", qif.in_ready, 1);
        push(64'h7000, addi(12));
        chk("post_reset_count", qif.count, 1);
        chk("post_reset_imm", qif.out_imm, 12);
        chk("post_reset_pc", qif.out_pc, 64'h7000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
